// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit.
// One step per cycle: shift-add for multiply and restoring shift-subtract for
// divide, both working on magnitudes in a 2*XLEN-bit accumulator. The sign is
// applied to the result when it is written back.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start_i          start request, only sampled in IDLE
//   func3_i          0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_data_i       multiplicand / dividend
//   rs2_data_i       multiplier / divisor
//   rd_addr_i        destination register, latched at start
//   flush_i          abort the operation in progress, suppress write-back
//   busy_o           high whenever the unit is not IDLE
//   hold_flag_o      pipeline stall request (start-accept cycle and CALC)
//   rd_addr_o        write-back register address (DONE only)
//   rd_data_o        write-back data (DONE only)
//   rd_wr_en         one-cycle write-back strobe
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | one multiply/divide step per cycle, XLEN steps in total
// DONE  | result presented with rd_wr_en for one cycle
module ex_muldiv #(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wr_en
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_raw;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic              neg, div_zero;

  logic              accept, last_step;
  logic              in_a_neg, in_b_neg, in_neg, in_div0;
  logic [XLEN-1:0]   in_a_mag, in_b_mag;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [XLEN-1:0]   result;

  assign accept    = (state == IDLE) && start_i && !flush_i;
  assign last_step = (cnt == CW'(XLEN - 1));

  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
  // MUL low bits do not depend on signedness, so treating it as signed is safe.
  assign in_a_neg = rs1_data_i[XLEN-1] &&
                    (func3_i == 3'd0 || func3_i == 3'd1 || func3_i == 3'd2 ||
                     func3_i == 3'd4 || func3_i == 3'd6);
  assign in_b_neg = rs2_data_i[XLEN-1] &&
                    (func3_i == 3'd0 || func3_i == 3'd1 ||
                     func3_i == 3'd4 || func3_i == 3'd6);
  assign in_a_mag = in_a_neg ? -rs1_data_i : rs1_data_i;
  assign in_b_mag = in_b_neg ? -rs2_data_i : rs2_data_i;
  // Remainder follows the dividend sign; everything else is sign(a)^sign(b).
  assign in_neg   = (func3_i == 3'd6) ? in_a_neg : (in_a_neg ^ in_b_neg);
  assign in_div0  = func3_i[2] && (rs2_data_i == '0);

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  // Divide:   acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign rem_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_diff = rem_sh - {1'b0, opnd};

  always_comb begin
    acc_step = {mul_sum, acc[XLEN-1:1]};
    if (op[2]) begin
      if (div_diff[XLEN]) acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nxt = (FAST_ZERO && in_div0) ? DONE : CALC;
        CALC:    if (last_step) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      op       <= '0;
      rd       <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= '0;
        op       <= func3_i;
        rd       <= rd_addr_i;
        a_raw    <= rs1_data_i;
        neg      <= in_neg;
        div_zero <= in_div0;
        acc      <= {{XLEN{1'b0}}, (func3_i[2] ? in_a_mag : in_b_mag)};
        opnd     <= func3_i[2] ? in_b_mag : in_a_mag;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Zero divisor is resolved from the flag, so the result is right whether
  // or not the iterations were skipped. Signed overflow needs no special case:
  // |-2^(XLEN-1)| / 1 negated wraps back to -2^(XLEN-1) with remainder 0.
  always_comb begin
    prod   = neg ? -acc : acc;
    result = '0;
    if (!op[2])        result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div_zero) result = op[1] ? a_raw : '1;
    else if (op[1])    result = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    else               result = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  end

  assign busy_o      = (state != IDLE);
  assign hold_flag_o = accept || (state == CALC);
  assign rd_wr_en    = (state == DONE) && !flush_i;
  assign rd_addr_o   = rd_wr_en ? rd : '0;
  assign rd_data_o   = rd_wr_en ? result : '0;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width in bits (even, >= 8).
REQ-002 Parameter FAST_ZERO, default 1, SHALL enable early completion on a zero divisor (1) or full-length iteration (0).
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  SHALL be the reset input: synchronous, active-high.
REQ-005 start_i  in  1  SHALL request a new operation; it is sampled only in IDLE.
REQ-006 func3_i  in  3  SHALL select the RV32M operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 rs1_data_i  in  XLEN  SHALL be operand 1 (multiplicand or dividend).
REQ-008 rs2_data_i  in  XLEN  SHALL be operand 2 (multiplier or divisor).
REQ-009 rd_addr_i  in  5  SHALL be the destination register, latched at start.
REQ-010 flush_i  in  1  SHALL abort any operation in progress (branch or jump redirect).
REQ-011 busy_o  out  1  SHALL be high whenever state is not IDLE.
REQ-012 hold_flag_o  out  1  SHALL request a pipeline stall.
REQ-013 rd_addr_o  out  5  SHALL give the write-back register address.
REQ-014 rd_data_o  out  XLEN  SHALL give the write-back data.
REQ-015 rd_wr_en  out  1  SHALL be the one-cycle write-back strobe.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-017 In IDLE, when start_i=1 and flush_i=0, the block SHALL do all of the following:
- latch func3_i, rd_addr_i and both operands;
- take absolute values for the signed operand(s) and record the result sign;
- clear the step counter;
- enter CALC.
REQ-018 In CALC, each cycle SHALL perform one step: a shift-add step for multiply, or a restoring shift-subtract step for divide, using a 2*XLEN-bit accumulator.
REQ-019 After XLEN steps, CALC SHALL enter DONE; the counter SHALL be $clog2(XLEN)+1 bits wide.
REQ-020 DONE SHALL last one cycle and then return to IDLE.
REQ-021 During DONE, the block SHALL drive the following:
- rd_wr_en = 1;
- rd_addr_o = the latched rd;
- rd_data_o = the sign-corrected result.
REQ-022 Start-to-write-back latency SHALL be XLEN+1 cycles: start accepted at cycle N gives rd_wr_en at cycle N+XLEN+1.
REQ-023 Result selection SHALL be as follows:
- MUL: low XLEN bits of the product;
- MULH, MULHSU, MULHU: high XLEN bits of the signed-signed, signed-unsigned and unsigned-unsigned product respectively;
- DIV, DIVU: quotient, truncated toward zero;
- REM, REMU: remainder, taking the sign of the dividend.
REQ-024 On a zero divisor, DIV and DIVU SHALL return all-ones and REM and REMU SHALL return the dividend.
REQ-025 With FAST_ZERO=1, a zero divisor SHALL go IDLE->DONE directly, giving a latency of 1 cycle.
REQ-026 Signed overflow (DIV or REM of -2^(XLEN-1) by -1) SHALL return quotient -2^(XLEN-1) and remainder 0.
REQ-027 hold_flag_o SHALL be high combinationally in the start-accept cycle and throughout CALC.
REQ-028 hold_flag_o SHALL be low in DONE, so the pipeline advances as the result is written.
REQ-029 start_i SHALL be ignored while busy_o=1; no queueing takes place.
REQ-030 flush_i=1 in any state SHALL force IDLE on the next edge.
REQ-031 A flush SHALL suppress rd_wr_en, including when it arrives during DONE.
REQ-032 Flush SHALL take priority over a simultaneous start_i.
REQ-033 Outside DONE, the following SHALL hold:
- rd_wr_en = 0;
- rd_data_o = 0;
- rd_addr_o = 0.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE and clear the counter, the accumulator and all latched operands.
REQ-035 After reset, busy_o, hold_flag_o, rd_wr_en, rd_addr_o and rd_data_o SHALL all be 0.
REQ-036 Reset SHALL take priority over flush_i and start_i.
REQ-037 Reset asserted mid-CALC SHALL discard the operation without any write-back.

Verification
REQ-038 MUL test: XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD -> rd_data_o=0xFFFFFFEB with rd_wr_en exactly 33 cycles after start.
REQ-039 High-product test: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-040 Signed divide test: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-041 Zero-divisor test, FAST_ZERO=1: DIVU 0x1234/0 -> 0xFFFFFFFF one cycle after start; REMU 0x1234/0 -> 0x1234.
REQ-042 Flush test: flush_i on the 10th CALC cycle -> no rd_wr_en and busy_o=0 next cycle; a following DIVU 100/7 -> 14.
REQ-043 Busy and reset test: start_i pulsed while busy -> ignored, and the original result is unchanged; rst mid-CALC -> all outputs 0 and no write-back.
